// File: rtl/text_buffer_ctrl.sv
// Character-cell buffer for the VGA text renderer: a terminal-style stream port and a
// random-access write port share the buffer, and a multi-cycle sweep clears it.
module text_buffer_ctrl #(
  parameter int         DEPTH       = 256,
  parameter int         ADDR_W      = 8,
  parameter logic [7:0] FILL_CHAR   = 8'h20,
  parameter bit         VBLANK_ONLY = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       vblank,
  input  logic                       ch_valid,
  input  logic [7:0]                 ch_data,
  output logic                       ch_ready,
  input  logic                       wr_req,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [7:0]                 wr_data,
  output logic                       wr_ack,
  input  logic                       clr_req,
  output logic [DEPTH-1:0][7:0]      text,
  output logic [ADDR_W-1:0]          cursor,
  output logic                       busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [7:0]        CH_BS   = 8'h08;
  localparam logic [7:0]        CH_FF   = 8'h0C;
  localparam logic [7:0]        CH_CR   = 8'h0D;
  localparam logic [ADDR_W-1:0] IDX_END = ADDR_W'(DEPTH - 1);

  state_t                  state_q;
  logic [DEPTH-1:0][7:0]   text_q;
  logic [ADDR_W-1:0]       cursor_q, clr_idx_q, cursor_dec;
  logic                    last_wr_q, busy_q, wr_ack_q;
  logic                    commit_ok, arb_ok, ch_gnt, wr_gnt;

  assign commit_ok  = !VBLANK_ONLY || vblank;
  assign arb_ok     = (state_q == IDLE) && commit_ok && !clr_req;
  // On contention the port that lost last time wins.
  assign ch_gnt     = arb_ok && ch_valid && (!wr_req || last_wr_q);
  assign wr_gnt     = arb_ok && wr_req && (!ch_valid || !last_wr_q);
  assign cursor_dec = cursor_q - 1'b1;

  assign ch_ready = ch_gnt;
  assign wr_ack   = wr_ack_q;
  assign text     = text_q;
  assign cursor   = cursor_q;
  assign busy     = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      text_q    <= {DEPTH{FILL_CHAR}};
      cursor_q  <= '0;
      clr_idx_q <= '0;
      last_wr_q <= 1'b1;
      busy_q    <= 1'b0;
      wr_ack_q  <= 1'b0;
    end else begin
      wr_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (commit_ok && clr_req) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            busy_q    <= 1'b1;
          end else if (ch_gnt) begin
            last_wr_q <= 1'b0;
            case (ch_data)
              CH_BS: if (cursor_q != '0) begin
                cursor_q           <= cursor_dec;
                text_q[cursor_dec] <= FILL_CHAR;
              end
              CH_FF: begin
                state_q   <= CLEAR;
                clr_idx_q <= '0;
                busy_q    <= 1'b1;
              end
              CH_CR:   cursor_q <= '0;
              default: begin
                text_q[cursor_q] <= ch_data;
                cursor_q         <= cursor_q + 1'b1;
              end
            endcase
          end else if (wr_gnt) begin
            last_wr_q       <= 1'b1;
            text_q[wr_addr] <= wr_data;
            wr_ack_q        <= 1'b1;
          end
        end
        CLEAR: if (commit_ok) begin
          text_q[clr_idx_q] <= FILL_CHAR;
          clr_idx_q         <= clr_idx_q + 1'b1;
          if (clr_idx_q == IDX_END) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            cursor_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Bench for text_buffer_ctrl: randomized stream/write/clear traffic against a cell-array
// reference model, plus directed stream, wrap, contention, clear and vblank-gated scenarios.
module tb_text_buffer_ctrl;
  localparam int         DEPTH = 256;
  localparam int         AW    = 8;
  localparam logic [7:0] FILL  = 8'h20;

  logic clk = 1'b0, rst_n = 1'b0, vblank = 1'b0;
  logic ch_valid = 1'b0, wr_req = 1'b0, clr_req = 1'b0;
  logic [7:0] ch_data = '0, wr_data = '0;
  logic [AW-1:0] wr_addr = '0;

  logic ch_ready, wr_ack, busy, vb_ch_ready, vb_wr_ack, vb_busy;
  logic [DEPTH-1:0][7:0] text, vb_text;
  logic [AW-1:0] cursor, vb_cursor;

  always #5 clk = ~clk;

  text_buffer_ctrl #(.DEPTH(DEPTH), .ADDR_W(AW), .FILL_CHAR(FILL), .VBLANK_ONLY(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .vblank(vblank), .ch_valid(ch_valid), .ch_data(ch_data),
    .ch_ready(ch_ready), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .clr_req(clr_req), .text(text), .cursor(cursor), .busy(busy));

  text_buffer_ctrl #(.DEPTH(DEPTH), .ADDR_W(AW), .FILL_CHAR(FILL), .VBLANK_ONLY(1'b1)) dut_vb (
    .clk(clk), .rst_n(rst_n), .vblank(vblank), .ch_valid(ch_valid), .ch_data(ch_data),
    .ch_ready(vb_ch_ready), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(vb_wr_ack),
    .clr_req(clr_req), .text(vb_text), .cursor(vb_cursor), .busy(vb_busy));

  int checks = 0, errors = 0;

  // Reference model of the always-commit instance: cell array, cursor, round-robin memory,
  // and number of cells still to be blanked by a running clear (0 = idle).
  logic [7:0] m_text [DEPTH];
  int         m_cursor, m_clr_left;
  bit         m_last_wr, m_ack;

  task automatic model_reset();
    foreach (m_text[i]) m_text[i] = FILL;
    m_cursor = 0; m_clr_left = 0; m_last_wr = 1'b1; m_ack = 1'b0;
  endtask

  function automatic bit exp_ready();
    return (m_clr_left == 0) && !clr_req && ch_valid && (!wr_req || m_last_wr);
  endfunction

  function automatic int text_diff(input logic [DEPTH-1:0][7:0] t);
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (t[i] !== m_text[i]) n++;
    return n;
  endfunction

  function automatic int count_not(input logic [DEPTH-1:0][7:0] t, input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (t[i] !== v) n++;
    return n;
  endfunction

  // Advance the model by one edge using the inputs currently applied, then clock the DUT.
  task automatic tick();
    m_ack = 1'b0;
    if (m_clr_left > 0) begin
      m_text[DEPTH - m_clr_left] = FILL;
      m_clr_left--;
      if (m_clr_left == 0) m_cursor = 0;
    end else if (clr_req) begin
      m_clr_left = DEPTH;
    end else if (ch_valid && (!wr_req || m_last_wr)) begin
      m_last_wr = 1'b0;
      case (ch_data)
        8'h08: if (m_cursor > 0) begin m_cursor--; m_text[m_cursor] = FILL; end
        8'h0C: m_clr_left = DEPTH;
        8'h0D: m_cursor = 0;
        default: begin m_text[m_cursor] = ch_data; m_cursor = (m_cursor + 1) % DEPTH; end
      endcase
    end else if (wr_req) begin
      m_last_wr = 1'b1;
      m_text[wr_addr] = wr_data;
      m_ack = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    checks++; if (count_not(text, FILL) != 0) begin errors++; $display("FAIL reset_text: %0d cells not 20", count_not(text, FILL)); end
    checks++; if (cursor !== 8'd0 || busy !== 1'b0 || wr_ack !== 1'b0) begin errors++; $display("FAIL reset_regs: cursor=%0h busy=%b ack=%b want 0", cursor, busy, wr_ack); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    ch_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin ch_data = 8'($urandom_range(33, 126)); tick(); end
    ch_valid = 1'b0; wr_req = 1'b1; wr_addr = 8'd77; wr_data = 8'h61;
    tick();
    wr_req = 1'b0;
    checks++; if (wr_ack !== 1'b1 || text[77] !== 8'h61) begin errors++; $display("FAIL pre_reset_write: ack=%b cell=%h want 1/61", wr_ack, text[77]); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (count_not(text, FILL) != 0 || cursor !== 8'd0 || busy !== 1'b0 || wr_ack !== 1'b0) begin
      errors++; $display("FAIL async_reset: dirty=%0d cursor=%0h busy=%b ack=%b want 0/0/0/0", count_not(text, FILL), cursor, busy, wr_ack);
    end
    model_reset();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    ch_valid = 1'b1; ch_data = 8'h41; #1;
    checks++; if (ch_ready !== 1'b1) begin errors++; $display("FAIL stream_ready: got %b want 1", ch_ready); end
    tick();
    ch_data = 8'h42; #1;
    checks++; if (ch_ready !== 1'b1) begin errors++; $display("FAIL stream_ready_b2b: got %b want 1", ch_ready); end
    tick();
    checks++; if (text[0] !== 8'h41 || text[1] !== 8'h42 || cursor !== 8'd2) begin
      errors++; $display("FAIL stream_AB: t0=%h t1=%h cursor=%0d want 41/42/2", text[0], text[1], cursor);
    end
    ch_data = 8'h08; tick();
    checks++; if (text[1] !== 8'h20 || cursor !== 8'd1 || text[0] !== 8'h41) begin
      errors++; $display("FAIL stream_bs: t0=%h t1=%h cursor=%0d want 41/20/1", text[0], text[1], cursor);
    end
    ch_data = 8'h0D; tick();
    checks++; if (cursor !== 8'd0 || text[0] !== 8'h41) begin errors++; $display("FAIL stream_cr: cursor=%0d t0=%h want 0/41", cursor, text[0]); end
    ch_data = 8'h08; tick();
    checks++; if (cursor !== 8'd0 || text[0] !== 8'h41) begin errors++; $display("FAIL stream_bs_sat: cursor=%0d t0=%h want 0/41", cursor, text[0]); end
    ch_valid = 1'b0;
    checks++; if (text_diff(text) != 0) begin errors++; $display("FAIL stream_model: %0d cells differ", text_diff(text)); end
  endtask

  task automatic test_wrap();
    logic [7:0] c;
    ch_valid = 1'b1; ch_data = 8'h58;
    for (int i = 0; i < DEPTH; i++) tick();
    checks++; if (count_not(text, 8'h58) != 0 || cursor !== 8'd0) begin
      errors++; $display("FAIL wrap_fill: not58=%0d cursor=%0d want 0/0", count_not(text, 8'h58), cursor);
    end
    c = 8'($urandom_range(33, 126)); ch_data = c; tick();
    ch_valid = 1'b0;
    checks++; if (text[0] !== c || text[1] !== 8'h58 || cursor !== 8'd1) begin
      errors++; $display("FAIL wrap_257: t0=%h t1=%h cursor=%0d want %h/58/1", text[0], text[1], cursor, c);
    end
  endtask

  task automatic test_contention();
    bit exp_ch;
    int start_cur;
    wr_req = 1'b1; wr_addr = 8'd200; wr_data = 8'($urandom); tick();
    checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL cont_prime_ack: got %b want 1", wr_ack); end
    start_cur = int'(cursor);
    ch_valid = 1'b1; ch_data = 8'h43; wr_addr = 8'h10; wr_data = 8'h7A;
    for (int k = 0; k < 4; k++) begin
      exp_ch = (k % 2 == 0);
      #1;
      checks++; if (ch_ready !== exp_ch) begin errors++; $display("FAIL cont_grant%0d: ch_ready=%b want %b", k, ch_ready, exp_ch); end
      tick();
      checks++; if (wr_ack !== !exp_ch) begin errors++; $display("FAIL cont_ack%0d: wr_ack=%b want %b", k, wr_ack, !exp_ch); end
    end
    ch_valid = 1'b0; wr_req = 1'b0;
    checks++; if (text[8'h10] !== 8'h7A || int'(cursor) != (start_cur + 2) % DEPTH || text_diff(text) != 0) begin
      errors++; $display("FAIL cont_result: t10=%h cursor=%0d diff=%0d want 7a/%0d/0", text[8'h10], cursor, text_diff(text), (start_cur + 2) % DEPTH);
    end
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 600; n++) begin
      ch_valid = 1'($urandom); wr_req = 1'($urandom); clr_req = ($urandom_range(0, 59) == 0);
      r = $urandom_range(0, 63);
      ch_data = (r == 0) ? 8'h0C : (r < 6) ? 8'h08 : (r < 8) ? 8'h0D : 8'($urandom_range(33, 126));
      wr_addr = 8'($urandom); wr_data = 8'($urandom);
      #1;
      checks++; if (ch_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready@%0d: got %b want %b", n, ch_ready, exp_ready()); end
      tick();
      checks++; if (wr_ack !== m_ack || busy !== (m_clr_left > 0)) begin
        errors++; $display("FAIL rnd_ack_busy@%0d: ack=%b busy=%b want %b/%b", n, wr_ack, busy, m_ack, m_clr_left > 0);
      end
      checks++; if (int'(cursor) != m_cursor) begin errors++; $display("FAIL rnd_cursor@%0d: got %0d want %0d", n, cursor, m_cursor); end
      checks++; if (text_diff(text) != 0) begin errors++; $display("FAIL rnd_text@%0d: %0d cells differ", n, text_diff(text)); end
    end
    ch_valid = 1'b0; wr_req = 1'b0; clr_req = 1'b0;
    for (int n = 0; n < DEPTH + 2 && m_clr_left > 0; n++) tick();
  endtask

  task automatic test_clear();
    int n, bad_rdy, bad_ack;
    for (int pass = 0; pass < 2; pass++) begin
      ch_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin ch_data = 8'($urandom_range(33, 126)); tick(); end
      if (pass == 0) begin
        clr_req = 1'b1; ch_data = 8'h5A; wr_req = 1'b1; wr_addr = 8'd5; wr_data = 8'h11;
        #1;
        checks++; if (ch_ready !== 1'b0) begin errors++; $display("FAIL clr_entry_ready: got %b want 0", ch_ready); end
      end else begin
        ch_data = 8'h0C;
      end
      tick();
      clr_req = 1'b0;
      if (pass == 1) ch_valid = 1'b0;
      n = 0; bad_rdy = 0; bad_ack = 0;
      while (busy === 1'b1 && n < 400) begin
        #1; if (ch_ready !== 1'b0) bad_rdy++;
        tick(); n++;
        if (wr_ack !== 1'b0) bad_ack++;
      end
      ch_valid = 1'b0; wr_req = 1'b0;
      checks++; if (n != DEPTH) begin errors++; $display("FAIL clr_len%0d: busy %0d cycles want %0d", pass, n, DEPTH); end
      checks++; if (bad_rdy != 0 || bad_ack != 0) begin errors++; $display("FAIL clr_blocked%0d: ready_hi=%0d ack_hi=%0d want 0/0", pass, bad_rdy, bad_ack); end
      checks++; if (count_not(text, FILL) != 0 || cursor !== 8'd0 || text_diff(text) != 0) begin
        errors++; $display("FAIL clr_result%0d: dirty=%0d cursor=%0d want 0/0", pass, count_not(text, FILL), cursor);
      end
    end
  endtask

  task automatic test_vblank();
    int commits, n;
    #1 rst_n = 1'b0; #1 rst_n = 1'b1;
    model_reset();
    vblank = 1'b0; ch_valid = 1'b1; ch_data = 8'h51; wr_req = 1'b1; wr_addr = 8'd3; wr_data = 8'h55;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (vb_ch_ready !== 1'b0) begin errors++; $display("FAIL vb_ready_blocked%0d: got %b want 0", k, vb_ch_ready); end
      @(posedge clk); #1;
      checks++; if (vb_wr_ack !== 1'b0) begin errors++; $display("FAIL vb_ack_blocked%0d: got %b want 0", k, vb_wr_ack); end
    end
    checks++; if (count_not(vb_text, FILL) != 0 || vb_cursor !== 8'd0) begin errors++; $display("FAIL vb_no_commit: dirty=%0d cursor=%0d want 0/0", count_not(vb_text, FILL), vb_cursor); end
    vblank = 1'b1; wr_req = 1'b0;
    for (int k = 0; k < 20; k++) begin @(posedge clk); #1; end
    ch_valid = 1'b0;
    checks++; if (vb_cursor !== 8'd20 || vb_text[19] !== 8'h51) begin errors++; $display("FAIL vb_stream: cursor=%0d t19=%h want 20/51", vb_cursor, vb_text[19]); end
    vblank = 1'b0; clr_req = 1'b1; @(posedge clk); #1;
    checks++; if (vb_busy !== 1'b0) begin errors++; $display("FAIL vb_clr_gated: busy=%b want 0", vb_busy); end
    vblank = 1'b1; @(posedge clk); #1; clr_req = 1'b0;
    checks++; if (vb_busy !== 1'b1) begin errors++; $display("FAIL vb_clr_start: busy=%b want 1", vb_busy); end
    commits = 0; n = 0;
    while (vb_busy === 1'b1 && n < 2000) begin
      vblank = 1'($urandom);
      if (vblank) commits++;
      @(posedge clk); #1; n++;
    end
    checks++; if (commits != DEPTH || vb_busy !== 1'b0) begin errors++; $display("FAIL vb_clr_commits: %0d busy=%b want %0d/0", commits, vb_busy, DEPTH); end
    checks++; if (count_not(vb_text, FILL) != 0 || vb_cursor !== 8'd0) begin errors++; $display("FAIL vb_clr_result: dirty=%0d cursor=%0d want 0/0", count_not(vb_text, FILL), vb_cursor); end
    vblank = 1'b1; wr_req = 1'b1; wr_addr = 8'd200; wr_data = 8'h57;
    @(posedge clk); #1; wr_req = 1'b0;
    checks++; if (vb_wr_ack !== 1'b1 || vb_text[200] !== 8'h57) begin errors++; $display("FAIL vb_write: ack=%b t200=%h want 1/57", vb_wr_ack, vb_text[200]); end
    clr_req = 1'b1; @(posedge clk); #1; clr_req = 1'b0;
    for (int k = 0; k < 100; k++) begin @(posedge clk); #1; end
    vblank = 1'b0;
    checks++; if (vb_busy !== 1'b1 || vb_text[99] !== FILL) begin errors++; $display("FAIL vb_mid_clear: busy=%b want 1", vb_busy); end
    #2 rst_n = 1'b0; #1;
    checks++; if (vb_busy !== 1'b0 || count_not(vb_text, FILL) != 0 || vb_cursor !== 8'd0) begin
      errors++; $display("FAIL vb_reset_mid_clear: busy=%b dirty=%0d cursor=%0d want 0/0/0", vb_busy, count_not(vb_text, FILL), vb_cursor);
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    vblank = 1'b1; ch_valid = 1'b1; ch_data = 8'h41; #1;
    checks++; if (vb_ch_ready !== 1'b1) begin errors++; $display("FAIL vb_idle_after_reset: ready=%b want 1", vb_ch_ready); end
    @(posedge clk); #1; ch_valid = 1'b0;
    checks++; if (vb_text[0] !== 8'h41 || vb_busy !== 1'b0) begin errors++; $display("FAIL vb_post_reset_write: t0=%h busy=%b want 41/0", vb_text[0], vb_busy); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wrap();
    test_contention();
    test_random();
    test_clear();
    test_vblank();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
